// File: rtl/smem_pkg.sv
// Shared widths, FSM state encoding and the queued request format for the bank master.
package smem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/smem_req_fifo.sv
// Request buffer: power-of-two circular FIFO with occupancy count, full and empty flags.
module smem_req_fifo
  import smem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [REQ_W-1:0]         push_data,
  input  logic                     pop,
  output logic [REQ_W-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [REQ_W-1:0] slots [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/smem_master.sv
// Bank master: buffers core requests, issues one strobe per access and returns one response each.
// Define SMEM_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES with an error response.
module smem_master
  import smem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bank_read,
  output logic              bank_write,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata,
  input  logic              bank_finish
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e          state;
  req_t            incoming;
  req_t            head;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            wait_rd;

  assign incoming  = '{we: req_we, addr: req_addr, wdata: req_wdata};
  // Ready depends only on the registered occupancy, never on req_valid.
  assign req_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push = req_valid && !fifo_full;
  assign fifo_pop  = (state == StIdle) && !fifo_empty;

  smem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (incoming),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef SMEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      wait_rd    <= 1'b0;
      bank_read  <= 1'b0;
      bank_write <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
`ifdef SMEM_TIMEOUT_EN
      rsp_err    <= 1'b0;
      timer      <= '0;
`endif
    end else begin
      bank_read  <= 1'b0;
      bank_write <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
`ifdef SMEM_TIMEOUT_EN
      rsp_err    <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          // bank_finish is deliberately ignored here (spurious or late completions).
          if (!fifo_empty) begin
            bank_read  <= !head.we;
            bank_write <= head.we;
            bank_addr  <= head.addr;
            bank_wdata <= head.wdata;
            wait_rd    <= !head.we;
            state      <= StWait;
`ifdef SMEM_TIMEOUT_EN
            timer      <= '0;
`endif
          end
        end
        StWait: begin
          if (bank_finish) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= wait_rd ? bank_rdata : '0;
            state     <= StIdle;
          end
`ifdef SMEM_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= StIdle;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/smem_master.md
SMEM_MASTER -- requirements
Module: smem_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request-buffer entries (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYCLES, default 15, maximum WAIT cycles before error (used only with SMEM_TIMEOUT_EN).
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  core offers a request.
REQ-006 req_ready  out  1  request buffer not full.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  8  bank address.
REQ-009 req_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-cycle response pulse.
REQ-011 rsp_rdata  out  8  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  response is a timeout error.
REQ-013 bank_read / bank_write  out  1 each  one-cycle access strobes to the bank.
REQ-014 bank_addr / bank_wdata  out  8 each  access address and write data.
REQ-015 bank_rdata  in  8  bank read data; undefined/high-Z except when bank_finish=1 after a read.
REQ-016 bank_finish  in  1  bank completion, registered one cycle after a strobe.

Function
REQ-017 Request accepted on a rising edge where req_valid=1 and req_ready=1; stored in FIFO order.
REQ-018 req_ready = (FIFO occupancy < FIFO_DEPTH), registered state only, no combinational path from req_valid.
REQ-019 FSM states IDLE, WAIT; IDLE with FIFO non-empty: pop head, assert exactly one strobe for one cycle with addr/wdata, go WAIT.
REQ-020 WAIT with bank_finish=1: next cycle rsp_valid=1, rsp_rdata=captured bank_rdata (read) or 0 (write), rsp_err=0, return IDLE.
REQ-021 Latency from acceptance (edge E0) into empty idle block: strobe high after E1, rsp_valid high after E3.
REQ-022 Back-to-back throughput: one access per 3 cycles; next strobe no earlier than the cycle after rsp_valid.
REQ-023 bank_finish in IDLE ignored; bank_rdata never sampled without bank_finish.
REQ-024 Push on a full FIFO is refused (req_ready=0); pop and push in the same cycle both take effect.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; occupancy never exceeds FIFO_DEPTH nor goes below 0.
REQ-026 rsp_valid has no backpressure; the core always accepts responses.

Reset
REQ-027 reset low asynchronously clears FIFO, state to IDLE, timeout counter, all outputs to 0 except req_ready=1.
REQ-028 Reset mid-access drops the in-flight and queued requests; no response is generated for them.

Configuration
REQ-029 Macro SMEM_TIMEOUT_EN defined: WAIT counts cycles; after TIMEOUT_CYCLES without bank_finish, rsp_valid=1, rsp_err=1, rsp_rdata=0, return IDLE; a late bank_finish is then ignored.
REQ-030 SMEM_TIMEOUT_EN undefined: WAIT persists until bank_finish; rsp_err tied 0; no counter logic.

Structure
REQ-031 Package smem_pkg holds ADDR_W=8, DATA_W=8, FSM state enum, request struct (we, addr, wdata).
REQ-032 FIFO implemented as sub-module smem_req_fifo (push/pop/full/empty/count).

Verification
REQ-033 Single read: preload bank[0x10]=0xA5, request read 0x10 -> bank_read pulse 1 cycle, rsp_valid 3 cycles after acceptance, rsp_rdata=0xA5, rsp_err=0.
REQ-034 Write then read: write 0x3C to 0x20, read 0x20 -> write response rsp_rdata=0, read response 0x3C, order preserved.
REQ-035 Fill: 5 requests back-to-back with FIFO_DEPTH=4 and block busy -> req_ready low once 4 queued; all 5 complete in order.
REQ-036 Timeout (SMEM_TIMEOUT_EN, bank_finish held 0): read 0x01 -> rsp_valid with rsp_err=1, rsp_rdata=0 exactly 15 WAIT cycles after strobe.
REQ-037 Reset mid-WAIT with 2 queued: reset low -> outputs 0, req_ready=1, no responses after release; new request completes normally.
REQ-038 Spurious bank_finish in IDLE -> no rsp_valid, state unchanged.
